spi_sniffer_sync: RTL
=====================

Name: spi_sniffer_sync

Overview:
Clock-synchronous, passive SPI bus sniffer that decodes both MOSI and MISO into parallel words of configurable width. It supports all four CPOL/CPHA modes and MSB- or LSB-first ordering. A masked pattern-match trigger output feeds the IO trigger fabric. All SPI pins are oversampled on the system clock, so decoded data is delivered in the clk domain.

Parameters:
DATA_WIDTH, 8, bits per decoded word; legal range 4..32.
SYNC_STAGES, 2, synchroniser flops on each SPI input; legal range 2..4.
WCNT_WIDTH, 16, width of the per-frame word counter.

Ports:
clk  in  1  system clock; must be at least 4x the SCK frequency.
reset_n  in  1  asynchronous active-low reset.
sck  in  1  SPI clock pin (asynchronous).
cs_n  in  1  SPI chip select pin, active-low (asynchronous).
mosi  in  1  SPI MOSI pin (asynchronous).
miso  in  1  SPI MISO pin (asynchronous).
cfg_enable  in  1  decoder enable.
cfg_cpol  in  1  SCK idle level.
cfg_cpha  in  1  0 = sample on leading edge, 1 = sample on trailing edge.
cfg_lsb_first  in  1  1 = first bit received lands in bit 0.
match_en  in  1  enables trig_out.
match_data  in  DATA_WIDTH  compare value, checked against MOSI.
match_mask  in  DATA_WIDTH  1 = bit participates in the compare.
mosi_data  out  DATA_WIDTH  last completed MOSI word.
miso_data  out  DATA_WIDTH  last completed MISO word.
data_valid  out  1  one-clk pulse when a word completes.
word_count  out  WCNT_WIDTH  number of completed words in the current frame.
frame_start  out  1  one-clk pulse when CS asserts.
frame_end  out  1  one-clk pulse when CS deasserts.
partial_err  out  1  one-clk pulse when CS deasserts with bits pending.
trig_out  out  1  one-clk pulse when a completed word matches.

Behaviour:
- Reset (reset_n low, asynchronous): all outputs are 0; the FSM is in IDLE; the bit counter, shift registers and synchronisers are cleared. Synchroniser flops reset to 1 for cs_n and to 0 for all other pins.
- Input conditioning: each pin passes through SYNC_STAGES flops, then one history flop for edge detection. Data pins go through the same depth as sck, so they stay aligned with it.
- Sample edge: rising SCK edge when (cpol XOR cpha) = 0, falling edge otherwise. An edge is detected in cycle N when sck_sync differs from sck_prev.
- Config capture: cpol, cpha and lsb_first are latched on entering ACTIVE and held for the whole frame. Changes made mid-frame are ignored.
- FSM states: DISABLED, IDLE, ACTIVE.
- DISABLED: entered whenever cfg_enable = 0, from any state, within 1 clk. Pending bits are discarded and no output pulses are generated. When cfg_enable returns to 1, the FSM goes to IDLE only after cs_n_sync = 1 has been seen, so it never joins a frame mid-way.
- IDLE: when cs_n_sync falls, go to ACTIVE. Clear bit_cnt and word_count, and pulse frame_start.
- ACTIVE, on each sample edge:
  - Shift mosi_sync and miso_sync into their shift registers. With MSB-first, shift left and insert at bit 0. With LSB-first, shift right and insert at the MSB.
  - Increment bit_cnt.
  - When bit_cnt = DATA_WIDTH-1: load mosi_data and miso_data, pulse data_valid, increment word_count (saturating at all-ones), and wrap bit_cnt to 0.
- Output timing: outputs are registered in cycle N and visible in cycle N+1. Total latency from the pin edge to data_valid is SYNC_STAGES+1 clk, with ±1 clk of synchroniser uncertainty.
- ACTIVE, on cs_n_sync rising: pulse frame_end and return to IDLE. If bit_cnt != 0, also pulse partial_err; the partial bits never reach mosi_data.
- Simultaneous sample edge and CS rise in the same cycle: the edge is processed first. If it completes a word, data_valid and frame_end pulse together and partial_err stays 0.
- Non-sampling edges (launch edges) are ignored.
- Between words, mosi_data, miso_data and word_count hold their values; word_count holds after the frame ends.
- trig_out: asserted in the same cycle as data_valid when match_en = 1 and ((next mosi_data XOR match_data) AND match_mask) = 0. With match_mask = 0, every word triggers.
- No output pulse ever lasts longer than 1 clk.

Decomposition:
- Shared header (includes.v style): FSM state encodings (DISABLED = 2'd0, IDLE = 2'd1, ACTIVE = 2'd2), plus legal-range checks for DATA_WIDTH and SYNC_STAGES.
- One sub-module, spi_pin_sync: a SYNC_STAGES-deep synchroniser plus history flop, parametrised by reset value. It outputs the synced level and rise/fall strobes and is instantiated for sck, cs_n, mosi and miso.
- Top level: FSM, shift registers, counters, match logic.

Test Plan:
- Mode 0, MSB-first, W = 8, clk = 8x SCK. Send MOSI 0xA5 and MISO 0x3C in one frame -> data_valid once; mosi_data = 0xA5, miso_data = 0x3C; word_count = 1; frame_start and frame_end once each.
- All four modes with LSB-first, sending MOSI 0x01 -> mosi_data = 0x01 in every mode. Same test with MSB-first -> mosi_data = 0x80.
- W = 16, one frame of 3 words (0x1234, 0xBEEF, 0x0000) -> three data_valid pulses in that order; word_count = 3 after the frame.
- CS deasserted after 5 of 8 bits -> partial_err and frame_end pulse; data_valid stays 0; mosi_data unchanged from the prior value.
- match_data = 0xA0, match_mask = 0xF0, send MOSI 0xA7 then 0xB7 -> trig_out fires for 0xA7 only. With match_en = 0 -> no trig_out.
- Asynchronous reset_n pulse mid-word, then a fresh frame with 0x5A -> all outputs 0 immediately on reset; the new frame decodes 0x5A with word_count = 1. Dropping cfg_enable mid-frame -> no pulses, and decoding resumes only at the next CS assertion.

Source files
------------

// File: rtl/spi_sniffer_sync_pkg.sv
// Shared definitions for the SPI sniffer: FSM encoding and parameter range limits.
package spi_sniffer_sync_pkg;

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    IDLE     = 2'd1,
    ACTIVE   = 2'd2
  } state_t;

  localparam int DW_MIN   = 4;
  localparam int DW_MAX   = 32;
  localparam int SYNC_MIN = 2;
  localparam int SYNC_MAX = 4;

  function automatic bit in_range(input int v, input int lo, input int hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Multi-flop synchroniser for one asynchronous SPI pin, plus a history flop
// giving single-cycle rise/fall strobes on the synchronised level.
module spi_pin_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_reg;
  logic              prev_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_reg <= {STAGES{RST_VAL}};
      prev_reg <= RST_VAL;
    end else begin
      sync_reg <= {sync_reg[STAGES-2:0], pin};
      prev_reg <= sync_reg[STAGES-1];
    end
  end

  assign level = sync_reg[STAGES-1];
  assign rise  = level & ~prev_reg;
  assign fall  = ~level & prev_reg;

endmodule

// File: rtl/spi_sniffer_sync.sv
// Passive SPI sniffer: oversamples the bus on clk and decodes MOSI/MISO into
// parallel words with per-frame word counting and a masked MOSI match trigger.
module spi_sniffer_sync
  import spi_sniffer_sync_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int WCNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  sck,
  input  logic                  cs_n,
  input  logic                  mosi,
  input  logic                  miso,
  input  logic                  cfg_enable,
  input  logic                  cfg_cpol,
  input  logic                  cfg_cpha,
  input  logic                  cfg_lsb_first,
  input  logic                  match_en,
  input  logic [DATA_WIDTH-1:0] match_data,
  input  logic [DATA_WIDTH-1:0] match_mask,
  output logic [DATA_WIDTH-1:0] mosi_data,
  output logic [DATA_WIDTH-1:0] miso_data,
  output logic                  data_valid,
  output logic [WCNT_WIDTH-1:0] word_count,
  output logic                  frame_start,
  output logic                  frame_end,
  output logic                  partial_err,
  output logic                  trig_out
);

  localparam int BCW = $clog2(DATA_WIDTH);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);

  if (!in_range(DATA_WIDTH, DW_MIN, DW_MAX)) begin : g_bad_dw
    $error("spi_sniffer_sync: DATA_WIDTH out of range 4..32");
  end
  if (!in_range(SYNC_STAGES, SYNC_MIN, SYNC_MAX)) begin : g_bad_sync
    $error("spi_sniffer_sync: SYNC_STAGES out of range 2..4");
  end

  // Pin order {miso, mosi, cs_n, sck}; only cs_n idles high.
  logic [3:0] pin_raw, pin_level, pin_rise, pin_fall;
  assign pin_raw = {miso, mosi, cs_n, sck};

  for (genvar gi = 0; gi < 4; gi++) begin : g_pin
    spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(gi == 1)) u_sync (
      .clk    (clk),
      .reset_n(reset_n),
      .pin    (pin_raw[gi]),
      .level  (pin_level[gi]),
      .rise   (pin_rise[gi]),
      .fall   (pin_fall[gi])
    );
  end

  logic unused_edges;
  assign unused_edges = ^{pin_rise[3:2], pin_fall[3:2], pin_level[0]};

  state_t                state_reg, state_next;
  logic [BCW-1:0]        bit_cnt_reg, bit_cnt_next;
  logic [DATA_WIDTH-1:0] mosi_sh_reg, mosi_sh_next, miso_sh_reg, miso_sh_next;
  logic [DATA_WIDTH-1:0] mosi_data_reg, mosi_data_next, miso_data_reg, miso_data_next;
  logic [WCNT_WIDTH-1:0] wcnt_reg, wcnt_next;
  logic                  sample_rise_reg, sample_rise_next, lsb_reg, lsb_next;
  logic                  valid_reg, valid_next, fs_reg, fs_next, fe_reg, fe_next;
  logic                  pe_reg, pe_next, trig_reg, trig_next;
  logic                  sample_edge;

  assign sample_edge = sample_rise_reg ? pin_rise[0] : pin_fall[0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= IDLE;
      bit_cnt_reg     <= '0;
      mosi_sh_reg     <= '0;
      miso_sh_reg     <= '0;
      mosi_data_reg   <= '0;
      miso_data_reg   <= '0;
      wcnt_reg        <= '0;
      sample_rise_reg <= 1'b1;
      lsb_reg         <= 1'b0;
      valid_reg       <= 1'b0;
      fs_reg          <= 1'b0;
      fe_reg          <= 1'b0;
      pe_reg          <= 1'b0;
      trig_reg        <= 1'b0;
    end else begin
      state_reg       <= state_next;
      bit_cnt_reg     <= bit_cnt_next;
      mosi_sh_reg     <= mosi_sh_next;
      miso_sh_reg     <= miso_sh_next;
      mosi_data_reg   <= mosi_data_next;
      miso_data_reg   <= miso_data_next;
      wcnt_reg        <= wcnt_next;
      sample_rise_reg <= sample_rise_next;
      lsb_reg         <= lsb_next;
      valid_reg       <= valid_next;
      fs_reg          <= fs_next;
      fe_reg          <= fe_next;
      pe_reg          <= pe_next;
      trig_reg        <= trig_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    bit_cnt_next     = bit_cnt_reg;
    mosi_sh_next     = mosi_sh_reg;
    miso_sh_next     = miso_sh_reg;
    mosi_data_next   = mosi_data_reg;
    miso_data_next   = miso_data_reg;
    wcnt_next        = wcnt_reg;
    sample_rise_next = sample_rise_reg;
    lsb_next         = lsb_reg;
    valid_next       = 1'b0;
    fs_next          = 1'b0;
    fe_next          = 1'b0;
    pe_next          = 1'b0;
    trig_next        = 1'b0;

    if (!cfg_enable) begin
      state_next   = DISABLED;
      bit_cnt_next = '0;
    end else begin
      case (state_reg)
        DISABLED: if (pin_level[1]) state_next = IDLE;
        IDLE: begin
          if (pin_fall[1]) begin
            state_next       = ACTIVE;
            bit_cnt_next     = '0;
            wcnt_next        = '0;
            fs_next          = 1'b1;
            sample_rise_next = ~(cfg_cpol ^ cfg_cpha);
            lsb_next         = cfg_lsb_first;
          end
        end
        ACTIVE: begin
          if (sample_edge) begin
            mosi_sh_next = lsb_reg ? {pin_level[2], mosi_sh_reg[DATA_WIDTH-1:1]}
                                   : {mosi_sh_reg[DATA_WIDTH-2:0], pin_level[2]};
            miso_sh_next = lsb_reg ? {pin_level[3], miso_sh_reg[DATA_WIDTH-1:1]}
                                   : {miso_sh_reg[DATA_WIDTH-2:0], pin_level[3]};
            if (bit_cnt_reg == LAST_BIT) begin
              bit_cnt_next   = '0;
              mosi_data_next = mosi_sh_next;
              miso_data_next = miso_sh_next;
              valid_next     = 1'b1;
              if (wcnt_reg != '1) wcnt_next = wcnt_reg + 1'b1;
              trig_next = match_en && (((mosi_sh_next ^ match_data) & match_mask) == '0);
            end else begin
              bit_cnt_next = bit_cnt_reg + 1'b1;
            end
          end
          // Edge in the same cycle is already folded into bit_cnt_next.
          if (pin_rise[1]) begin
            state_next = IDLE;
            fe_next    = 1'b1;
            pe_next    = (bit_cnt_next != '0);
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign mosi_data   = mosi_data_reg;
  assign miso_data   = miso_data_reg;
  assign data_valid  = valid_reg;
  assign word_count  = wcnt_reg;
  assign frame_start = fs_reg;
  assign frame_end   = fe_reg;
  assign partial_err = pe_reg;
  assign trig_out    = trig_reg;

endmodule
